// File: rtl/mul_step_seq_if.sv
// ============================================================================
// mul_step_seq_if
// ----------------------------------------------------------------------------
// Bundles the signals between the multiply sequencer, its controlling
// microsequencer and the cascaded mc10181 adder slices.
//
// Vectors are big-endian [0:N-1]; bit 0 is the MSB.
//
// Signals:
//   start    controller -> seq   begin a multiply (sampled only in IDLE)
//   md       controller -> seq   multiplicand, captured on accepted start
//   mq       controller -> seq   multiplier, captured on accepted start
//   busy     seq -> controller   high while stepping
//   done     seq -> controller   one-cycle pulse, product valid
//   prodHi   seq -> controller   high half of the product (AC)
//   prodLo   seq -> controller   low half of the product (MQ)
//   aluS     seq -> slices       S[0:3] function select to every slice
//   aluM     seq -> slices       mode (1 = logic, 0 = arithmetic)
//   aluCIN   seq -> slices       carry into the least-significant slice
//   aluA     seq -> slices       A operand (always AC)
//   aluB     seq -> slices       B operand (always MD)
//   aluF     slices -> seq       combinational result
//   aluCOUT  slices -> seq       carry out of the most-significant slice
//
// Modports:
//   slave  : the sequencer side (mul_step_seq)
//   master : the controller / adder side
// ============================================================================
interface mul_step_seq_if #(
    parameter int WIDTH = 36
);
    logic               start;
    logic [0:WIDTH-1]   md;
    logic [0:WIDTH-1]   mq;
    logic               busy;
    logic               done;
    logic [0:WIDTH-1]   prodHi;
    logic [0:WIDTH-1]   prodLo;
    logic [0:3]         aluS;
    logic               aluM;
    logic               aluCIN;
    logic [0:WIDTH-1]   aluA;
    logic [0:WIDTH-1]   aluB;
    logic [0:WIDTH-1]   aluF;
    logic               aluCOUT;

    modport slave (
        input  start, md, mq, aluF, aluCOUT,
        output busy, done, prodHi, prodLo,
        output aluS, aluM, aluCIN, aluA, aluB
    );

    modport master (
        output start, md, mq, aluF, aluCOUT,
        input  busy, done, prodHi, prodLo,
        input  aluS, aluM, aluCIN, aluA, aluB
    );
endinterface

// File: rtl/mul_step_seq.sv
// ============================================================================
// mul_step_seq
// ----------------------------------------------------------------------------
// Iterative unsigned shift-and-add multiplier sequencer. It does not contain
// an adder: it drives an external WIDTH-bit adder made of cascaded mc10181
// slices (function select, mode, carry-in, A = AC, B = MD) and captures the
// adder result F plus the top carry-out once per clock.
//
// Each RUN step:
//   F      = MQ.lsb ? AC + MD : AC        (carry-out 0 when passing AC)
//   AC    <= {COUT, F[0:WIDTH-2]}         (sum shifted right, carry re-enters)
//   MQ    <= {F[WIDTH-1], MQ[0:WIDTH-2]}  (sum LSB shifts into the multiplier)
// After WIDTH steps {AC, MQ} holds the 2*WIDTH-bit unsigned product.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high; returns to IDLE with all registers zero
//   bus    mul_step_seq_if.slave: start/md/mq handshake, busy/done status,
//          prodHi/prodLo product and the adder-slice bus
//
// Parameters:
//   WIDTH  operand width; a multiple of 4 (one mc10181 per nibble)
// ============================================================================
module mul_step_seq #(
    parameter int WIDTH = 36
) (
    input  logic              clk,
    input  logic              reset,
    mul_step_seq_if.slave     bus
);

    localparam int CW = $clog2(WIDTH + 1);

    // mc10181 function codes used by the sequencer
    localparam logic [0:3] S_ADD   = 4'b0110;   // M=0: F = A plus B
    localparam logic [0:3] S_PASSA = 4'b0000;   // M=0: F = A, no carry
    localparam logic [0:3] S_LOGIC = 4'b1111;   // M=1: F = A, adder idle

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [0:WIDTH-1]   ac_reg,    ac_next;
    logic [0:WIDTH-1]   mq_reg,    mq_next;
    logic [0:WIDTH-1]   md_reg,    md_next;
    logic [CW-1:0]      cnt_reg,   cnt_next;

    logic [0:3]         alu_s;
    logic               alu_m;
    logic               alu_cin;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ac_reg    <= '0;
            mq_reg    <= '0;
            md_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ac_reg    <= ac_next;
            mq_reg    <= mq_next;
            md_reg    <= md_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, datapath update and adder control
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ac_next    = ac_reg;
        mq_next    = mq_reg;
        md_next    = md_reg;
        cnt_next   = cnt_reg;
        // Quiescent adder setting: logic mode, F follows A
        alu_s      = S_LOGIC;
        alu_m      = 1'b1;
        alu_cin    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    md_next    = bus.md;
                    mq_next    = bus.mq;
                    ac_next    = '0;
                    cnt_next   = CW'(WIDTH);
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                // The multiplier LSB picks add-or-pass for this step
                alu_s   = mq_reg[WIDTH-1] ? S_ADD : S_PASSA;
                alu_m   = 1'b0;
                alu_cin = 1'b0;

                // The carry-out is the bit a WIDTH-bit sum would lose; it
                // becomes the new MSB of AC as everything shifts right.
                ac_next  = {bus.aluCOUT, bus.aluF[0:WIDTH-2]};
                mq_next  = {bus.aluF[WIDTH-1], mq_reg[0:WIDTH-2]};
                cnt_next = cnt_reg - CW'(1);

                if (cnt_reg == CW'(1)) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy   = (state_reg == ST_RUN);
    assign bus.done   = (state_reg == ST_DONE);
    assign bus.prodHi = ac_reg;
    assign bus.prodLo = mq_reg;
    assign bus.aluS   = alu_s;
    assign bus.aluM   = alu_m;
    assign bus.aluCIN = alu_cin;
    assign bus.aluA   = ac_reg;
    assign bus.aluB   = md_reg;

endmodule

// File: tb/tb_mul_step_seq.sv
// ============================================================================
// tb_mul_step_seq
// ----------------------------------------------------------------------------
// Self-checking bench for mul_step_seq with WIDTH = 36. Models the mc10181
// slice chain as a behavioural adder, runs a table of hand-computed
// products, a few multi-cycle sequences (continuous start, mid-run reset)
// and a random sweep against a 72-bit reference product.
// ============================================================================
module tb_mul_step_seq;

    localparam int W = 36;

    logic clk;
    logic reset;

    mul_step_seq_if #(.WIDTH(W)) bus ();

    mul_step_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slice chain: only the two functions the sequencer uses
    // in arithmetic mode are modelled; everything else passes A.
    logic [0:W] sum_ext;
    always_comb begin
        sum_ext     = {1'b0, bus.aluA} + {1'b0, bus.aluB} + {{W{1'b0}}, bus.aluCIN};
        bus.aluF    = bus.aluA;
        bus.aluCOUT = 1'b0;
        if (!bus.aluM && bus.aluS == 4'b0110) begin
            bus.aluF    = sum_ext[1:W];
            bus.aluCOUT = sum_ext[0];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // busy and done must never overlap
    always @(negedge clk) begin
        checks++;
        if (bus.busy && bus.done) begin
            errors++;
            $display("FAIL busy_done_overlap actual=11 required=not both");
        end
    end

    // One complete multiply; checks per-step aluS/aluM, busy length and the
    // single-cycle done pulse. Returns the product seen while done is high.
    task automatic run_mul(input logic [0:W-1] a, input logic [0:W-1] b,
                           output logic [0:W-1] hi, output logic [0:W-1] lo);
        int nbusy;
        int guard;
        logic [0:3] exp_s;
        @(negedge clk);
        bus.start = 1'b1;
        bus.md    = a;
        bus.mq    = b;
        @(negedge clk);
        bus.start = 1'b0;
        nbusy = 0;
        guard = 0;
        while (!bus.done && guard < W + 8) begin
            if (bus.busy) begin
                if (nbusy < W) begin
                    exp_s = b[W-1-nbusy] ? 4'b0110 : 4'b0000;
                    check("step_alu_s", 72'(bus.aluS), 72'(exp_s));
                    check("step_alu_m", 72'(bus.aluM), 72'(0));
                end
                nbusy++;
            end
            @(negedge clk);
            guard++;
        end
        check("done_seen", 72'(bus.done), 72'(1));
        check("busy_cycles", 72'(nbusy), 72'(W));
        check("done_alu_s", 72'(bus.aluS), 72'(4'b1111));
        hi = bus.prodHi;
        lo = bus.prodLo;
        @(negedge clk);
        check("done_single", 72'(bus.done), 72'(0));
        check("idle_busy", 72'(bus.busy), 72'(0));
        check("held_product", {bus.prodHi, bus.prodLo}, {hi, lo});
    endtask

    typedef struct {
        logic [0:W-1] a;
        logic [0:W-1] b;
        logic [0:W-1] hi;
        logic [0:W-1] lo;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:W-1] hi, lo;
        logic [0:W-1] ra, rb;
        logic [0:2*W-1] ref_p;
        int ndone, nrise, guard;
        int done_cyc [4];
        int rise_cyc [4];
        logic prev_busy;

        vecs[0] = '{36'd3, 36'd5, 36'd0, 36'd15};
        vecs[1] = '{36'o777777777777, 36'o777777777777, 36'o777777777776, 36'o000000000001};
        vecs[2] = '{36'd0, 36'o123456701234, 36'd0, 36'd0};
        vecs[3] = '{36'd7, 36'd9, 36'd0, 36'd63};
        vecs[4] = '{36'o400000000000, 36'd2, 36'd1, 36'd0};
        vecs[5] = '{36'o400000000000, 36'o400000000000, 36'o200000000000, 36'd0};
        vecs[6] = '{36'o777777777777, 36'd1, 36'd0, 36'o777777777777};
        vecs[7] = '{36'd1, 36'o777777777777, 36'd0, 36'o777777777777};
        vecs[8] = '{36'h100000000, 36'h100000000, 36'h010000000, 36'd0};
        vecs[9] = '{36'd8, 36'd8, 36'd0, 36'd64};

        // Reset with start held high: reset wins
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.md    = 36'd5;
        bus.mq    = 36'd5;
        repeat (3) @(negedge clk);
        check("rst_busy", 72'(bus.busy), 72'(0));
        check("rst_done", 72'(bus.done), 72'(0));
        check("rst_prod", {bus.prodHi, bus.prodLo}, 72'(0));
        check("rst_alu_s", 72'(bus.aluS), 72'(4'b1111));
        check("rst_alu_m", 72'(bus.aluM), 72'(1));
        check("rst_alu_cin", 72'(bus.aluCIN), 72'(0));
        check("rst_alu_ab", {bus.aluA, bus.aluB}, 72'(0));
        bus.start = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        check("idle_no_start", 72'(bus.busy), 72'(0));

        // Table of hand-computed products
        for (int i = 0; i < 10; i++) begin
            run_mul(vecs[i].a, vecs[i].b, hi, lo);
            $display("TXN vec%0d md=%h mq=%h hi=%h lo=%h", i, vecs[i].a, vecs[i].b, hi, lo);
            check("vec_hi", 72'(hi), 72'(vecs[i].hi));
            check("vec_lo", 72'(lo), 72'(vecs[i].lo));
        end

        // start held high for 80 cycles: back-to-back runs, restart only
        // in the first IDLE cycle after done
        @(negedge clk);
        bus.start = 1'b1;
        bus.md    = 36'd7;
        bus.mq    = 36'd9;
        ndone = 0;
        nrise = 0;
        prev_busy = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (ndone < 4) done_cyc[ndone] = i;
                ndone++;
                check("cont_hi", 72'(bus.prodHi), 72'(0));
                check("cont_lo", 72'(bus.prodLo), 72'(63));
            end
            if (bus.busy && !prev_busy) begin
                if (nrise < 4) rise_cyc[nrise] = i;
                nrise++;
            end
            prev_busy = bus.busy;
        end
        bus.start = 1'b0;
        $display("TXN continuous-start done_pulses=%0d busy_starts=%0d", ndone, nrise);
        check("cont_ndone", 72'(ndone), 72'(2));
        check("cont_nrise", 72'(nrise), 72'(3));
        if (ndone >= 2) begin
            check("cont_done1", 72'(done_cyc[0]), 72'(W + 1));
            check("cont_done2", 72'(done_cyc[1]), 72'(2 * W + 3));
        end
        if (nrise >= 2) begin
            check("cont_rise1", 72'(rise_cyc[0]), 72'(1));
            check("cont_rise2", 72'(rise_cyc[1]), 72'(W + 3));
        end
        guard = 0;
        while (!bus.done && guard < 2 * W) begin
            @(negedge clk);
            guard++;
        end
        check("cont_third_done", 72'(bus.done), 72'(1));
        check("cont_third_lo", 72'(bus.prodLo), 72'(63));
        @(negedge clk);

        // Reset in the middle of a run
        @(negedge clk);
        bus.start = 1'b1;
        bus.md    = 36'o777777777777;
        bus.mq    = 36'o555555555555;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 72'(bus.busy), 72'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("TXN mid-run reset busy=%0b done=%0b hi=%h lo=%h", bus.busy, bus.done, bus.prodHi, bus.prodLo);
        check("mrst_busy", 72'(bus.busy), 72'(0));
        check("mrst_done", 72'(bus.done), 72'(0));
        check("mrst_prod", {bus.prodHi, bus.prodLo}, 72'(0));
        check("mrst_alu_s", 72'(bus.aluS), 72'(4'b1111));
        check("mrst_alu_m", 72'(bus.aluM), 72'(1));
        ndone = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        check("mrst_quiet", 72'(ndone), 72'(0));
        run_mul(36'd2, 36'd2, hi, lo);
        $display("TXN after-reset md=2 mq=2 hi=%h lo=%h", hi, lo);
        check("mrst_after", {hi, lo}, 72'(4));

        // Random sweep against a 72-bit reference product
        for (int i = 0; i < 1000; i++) begin
            ra = W'({$urandom(), $urandom()});
            rb = W'({$urandom(), $urandom()});
            if (i % 7 == 0) ra = ra | 36'o400000000000;
            ref_p = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            run_mul(ra, rb, hi, lo);
            $display("TXN rand%0d md=%h mq=%h prod=%h", i, ra, rb, {hi, lo});
            check("rand_prod", {hi, lo}, ref_p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
